// File: rtl/bias_add_12_pkg.sv
// bias_add_12_pkg: shared layer-12 sizes, FSM state encoding and a counter
// width helper for the bias-add stage.
//   COEFF_WIDTH   bias word width (signed)
//   KERN_S_K_12   output channels of conv 12 (biases per frame)
//   ACC_WIDTH_12  accumulator word width
//   OUT_WIDTH_12  output word width
//   N_PIX_12      pixels per frame
//   SHIFT_12      arithmetic right shift after the bias add
package bias_add_12_pkg;

    localparam int COEFF_WIDTH  = 16;
    localparam int KERN_S_K_12  = 16;
    localparam int ACC_WIDTH_12 = 32;
    localparam int OUT_WIDTH_12 = 16;
    localparam int N_PIX_12     = 64;
    localparam int SHIFT_12     = 0;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Counter width that stays legal when the count is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_add_12_bias_sat.sv
// bias_sat: combinational bias add, arithmetic shift and saturation.
//   acc_i   ACC_W   signed accumulator word
//   bias_i  COEFF_W signed bias word (COEFF_W <= ACC_W)
//   res_o   OUT_W   signed result, saturated to the OUT_W range
// Optional feature macro: BIAS_ADD_RELU_EN clamps negative results to 0.
module bias_sat #(
    parameter int ACC_W   = 32,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 0
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [COEFF_W-1:0] bias_i,
    output logic [OUT_W-1:0]   res_o
);

    // One guard bit is enough: the sum of two ACC_W-bit signed values fits ACC_W+1.
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shf;
    logic [OUT_W-1:0]     sat;

    always_comb begin
        sum = $signed({acc_i[ACC_W-1], acc_i})
            + $signed({{(SW-COEFF_W){bias_i[COEFF_W-1]}}, bias_i});
        // >>> on a signed value floors toward -inf.
        shf = sum >>> SHIFT;
        if (shf > MAX_V) begin
            sat = MAX_V[OUT_W-1:0];
        end else if (shf < MIN_V) begin
            sat = MIN_V[OUT_W-1:0];
        end else begin
            sat = shf[OUT_W-1:0];
        end
        res_o = sat;
`ifdef BIAS_ADD_RELU_EN
        if (sat[OUT_W-1]) res_o = '0;
`endif
    end

endmodule

// File: rtl/bias_add_12.sv
// bias_add_12: loads OUT_CH biases from the bias FIFO, then adds the matching
// bias to each of N_PIX*OUT_CH accumulator words, shifts, saturates and pushes
// the result to the output FIFO. All streams are ap_fifo (FWFT inputs).
//   ap_clk / ap_rst_n           clock, async active-low reset
//   bias_V_dout/_empty_n/_read  bias FIFO read side
//   acc_V_dout/_empty_n/_read   accumulator FIFO read side (pixel-major)
//   output_V_din/_full_n/_write output FIFO write side
//   frame_done                  pulse with the frame's last output write
// Optional feature macro: BIAS_ADD_RELU_EN (ReLU after saturation, in bias_sat).
module bias_add_12
    import bias_add_12_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int ACC_W   = ACC_WIDTH_12,
    parameter int OUT_W   = OUT_WIDTH_12,
    parameter int OUT_CH  = KERN_S_K_12,
    parameter int N_PIX   = N_PIX_12,
    parameter int SHIFT   = SHIFT_12
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   acc_V_dout,
    input  logic               acc_V_empty_n,
    output logic               acc_V_read,
    output logic [OUT_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write,
    output logic               frame_done
);

    localparam int CH_W  = cnt_w(OUT_CH);
    localparam int PIX_W = cnt_w(N_PIX);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(OUT_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  bcnt_q, bcnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             ovalid_q, ovalid_d;
    logic [OUT_W-1:0] odata_q, odata_d;
    logic [COEFF_W-1:0] bias_mem_q [OUT_CH];
    logic [OUT_W-1:0] sat_res;
    logic             owrite;

    bias_sat #(
        .ACC_W   (ACC_W),
        .COEFF_W (COEFF_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT)
    ) u_sat (
        .acc_i  (acc_V_dout),
        .bias_i (bias_mem_q[ch_q]),
        .res_o  (sat_res)
    );

    // bias_V_read is combinational on empty_n; the reset term keeps it low
    // while reset is held even if the bias FIFO already has data.
    assign bias_V_read    = ap_rst_n & (state_q == ST_LOAD) & bias_V_empty_n;
    assign acc_V_read     = (state_q == ST_RUN) & acc_V_empty_n & (~ovalid_q | output_V_full_n);
    assign owrite         = ovalid_q & output_V_full_n;
    assign output_V_write = owrite;
    assign output_V_din   = odata_q;
    // In DRAIN the only word left in the register is the frame's last one.
    assign frame_done     = (state_q == ST_DRAIN) & owrite;

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        ch_d     = ch_q;
        pix_d    = pix_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;

        case (state_q)
            ST_LOAD: begin
                if (bias_V_read) begin
                    if (bcnt_q == CH_LAST) begin
                        bcnt_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (acc_V_read) begin
                    if (ch_q == CH_LAST) begin
                        ch_d = '0;
                        if (pix_q == PIX_LAST) begin
                            pix_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (owrite) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase

        // A pop reloads the register in the same cycle it drains: no bubble.
        if (acc_V_read) begin
            ovalid_d = 1'b1;
            odata_d  = sat_res;
        end else if (owrite) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= ST_LOAD;
            bcnt_q   <= '0;
            ch_q     <= '0;
            pix_q    <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            ch_q     <= ch_d;
            pix_q    <= pix_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
        end
    end

    // Bias storage needs no reset: every entry is rewritten before use.
    always_ff @(posedge ap_clk) begin
        if (bias_V_read) bias_mem_q[bcnt_q] <= bias_V_dout;
    end

endmodule

// File: tb/tb_bias_add_12.sv
module tb_bias_add_12;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [15:0] bias_V_dout;
    logic        bias_V_empty_n;
    logic        bias_V_read, b2_read;
    logic [31:0] acc_V_dout;
    logic        acc_V_empty_n;
    logic        acc_V_read, a2_read;
    logic [7:0]  output_V_din, out2_din;
    logic        output_V_full_n;
    logic        output_V_write, w2_write;
    logic        frame_done, fd2;

    always #5 ap_clk = ~ap_clk;

    bias_add_12 #(.COEFF_W(16), .ACC_W(32), .OUT_W(8), .OUT_CH(4), .N_PIX(2), .SHIFT(0)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
        .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read),
        .output_V_din(output_V_din), .output_V_full_n(output_V_full_n),
        .output_V_write(output_V_write), .frame_done(frame_done)
    );

    // Same stimulus, SHIFT=2: exercises the floor shift.
    bias_add_12 #(.COEFF_W(16), .ACC_W(32), .OUT_W(8), .OUT_CH(4), .N_PIX(2), .SHIFT(2)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(b2_read),
        .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(a2_read),
        .output_V_din(out2_din), .output_V_full_n(output_V_full_n),
        .output_V_write(w2_write), .frame_done(fd2)
    );

    int bq[$], aq[$], exp_q[$], exp2_q[$];
    int checks = 0, passes = 0, fails = 0;
    int step = 0, fd_step = -1, fd_cnt = 0, wr_frame = 0, bias_pops = 0;
    bit bias_gate = 1'b1, bias_toggle = 1'b0, starve_chk = 1'b0, stall_chk = 1'b0;
    int held = 0;

    function automatic int relu(input int v);
`ifdef BIAS_ADD_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive();
        bias_V_empty_n = (bq.size() > 0) && bias_gate;
        bias_V_dout    = (bq.size() > 0) ? 16'(bq[0]) : 16'd0;
        acc_V_empty_n  = (aq.size() > 0);
        acc_V_dout     = (aq.size() > 0) ? 32'(aq[0]) : 32'd0;
    endtask

    task automatic cyc();
        logic b_rd, a_rd, wr, fd;
        int din, din2, e, e2, exp_fd;
        @(negedge ap_clk);
        b_rd = bias_V_read; a_rd = acc_V_read; wr = output_V_write; fd = frame_done;
        din = int'($signed(output_V_din)); din2 = int'($signed(out2_din));
        if (b_rd && !bias_V_empty_n) chk("bias_read_while_empty", 1, 0);
        if (wr && !output_V_full_n) chk("write_while_full", 1, 0);
        if (starve_chk && bias_pops < 4) chk("starve_acc_read", int'(a_rd), 0);
        if (stall_chk) begin
            chk("stall_acc_read", int'(a_rd), 0);
            chk("stall_write", int'(wr), 0);
            chk("stall_hold", din, held);
        end
        @(posedge ap_clk); #1;
        if (b_rd) begin void'(bq.pop_front()); bias_pops++; end
        if (a_rd) void'(aq.pop_front());
        exp_fd = 0;
        if (wr) begin
            wr_frame++;
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = exp_q.pop_front(); e2 = exp2_q.pop_front();
                chk("out_data", din, e);
                chk("out_data_shift2", din2, e2);
                exp_fd = (exp_q.size() == 0) ? 1 : 0;
            end
        end
        if (fd) begin fd_step = step; fd_cnt++; end
        if (fd !== 1'(exp_fd)) chk("frame_done", int'(fd), exp_fd);
        if (bias_toggle) bias_gate = !bias_gate;
        drive();
        step++;
    endtask

    task automatic run_frame(input string tag);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) cyc();
        chk({tag, "_complete"}, exp_q.size(), 0);
    endtask

    task automatic load_basic(input int acc);
        int b[4] = '{1, -2, 3, 0};
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) aq.push_back(acc);
        for (int c = 0; c < 4; c++) bq.push_back(b[c]);
    endtask

    task automatic exp_basic10();
        int e[4] = '{11, 8, 13, 10}, e2[4] = '{2, 2, 3, 2};
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin exp_q.push_back(e[c]); exp2_q.push_back(e2[c]); end
    endtask

    initial begin
        int sa[8] = '{200, -300, 7, -7, 0, -5, 5, 0};
        int se[8] = '{127, -128, 7, -7, 100, -5, 5, 0};
        int se2[8] = '{75, -75, 1, -2, 25, -2, 1, 0};
        int re[4] = '{21, 18, 23, 20}, re2[4] = '{5, 4, 5, 5};

        // Reset state, with data already waiting in both input FIFOs.
        ap_rst_n = 1'b0; output_V_full_n = 1'b1;
        load_basic(10);
        bq.push_back(100); bq.push_back(0); bq.push_back(0); bq.push_back(0);
        drive();
        #12;
        chk("rst_bias_read", int'(bias_V_read), 0);
        chk("rst_acc_read", int'(acc_V_read), 0);
        chk("rst_din", int'(output_V_din), 0);
        chk("rst_write", int'(output_V_write), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(posedge ap_clk); #1; ap_rst_n = 1'b1;

        // Basic frame: last write (and frame_done) 12 cycles after reset release.
        step = 0; fd_cnt = 0;
        exp_basic10();
        run_frame("basic");
        chk("basic_fd_cycle", fd_step, 12);
        chk("basic_fd_count", fd_cnt, 1);
        chk("basic_bias_untouched_in_run", bq.size(), 4);

        // Saturation and floor shift; second bias set is already queued.
        for (int i = 0; i < 8; i++) begin
            aq.push_back(sa[i]); exp_q.push_back(relu(se[i])); exp2_q.push_back(relu(se2[i]));
        end
        run_frame("sat");

        // Backpressure: 5 stalled cycles after the 3rd write.
        load_basic(10); exp_basic10(); wr_frame = 0;
        for (int i = 0; i < 100 && wr_frame < 3; i++) cyc();
        output_V_full_n = 1'b0; held = int'($signed(output_V_din)); stall_chk = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        stall_chk = 1'b0; output_V_full_n = 1'b1;
        run_frame("bp");

        // Bias starvation: accumulator words present, bias empty_n toggling.
        load_basic(10); exp_basic10();
        bias_gate = 1'b0; bias_toggle = 1'b1; bias_pops = 0; starve_chk = 1'b1;
        drive();
        run_frame("starve");
        chk("starve_bias_pops", bias_pops, 4);
        bias_toggle = 1'b0; bias_gate = 1'b1; starve_chk = 1'b0;

        // Reset in the middle of RUN, next frame's biases already waiting.
        load_basic(10); exp_basic10(); wr_frame = 0;
        for (int i = 0; i < 100 && wr_frame < 3; i++) cyc();
        chk("mid_writes_before_reset", wr_frame, 3);
        bq.delete();
        bq.push_back(1); bq.push_back(-2); bq.push_back(3); bq.push_back(0);
        drive();
        #1 ap_rst_n = 1'b0;
        #1;
        chk("midrst_bias_read", int'(bias_V_read), 0);
        chk("midrst_acc_read", int'(acc_V_read), 0);
        chk("midrst_din", int'(output_V_din), 0);
        chk("midrst_write", int'(output_V_write), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        aq.delete(); exp_q.delete(); exp2_q.delete();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin
                aq.push_back(20); exp_q.push_back(re[c]); exp2_q.push_back(re2[c]);
            end
        drive();
        @(posedge ap_clk); #1; ap_rst_n = 1'b1;
        fd_cnt = 0;
        run_frame("after_reset");
        chk("after_reset_fd_count", fd_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
